// File: rtl/regfile_pkg.sv
// Shared constants and types for the RISCAT integer register file.
//   XLEN_DEF / NREGS_DEF / NRD_DEF : default build of regfile_sb
//   reg_addr_t / xword_t           : address and data types of the default build
package regfile_pkg;
  localparam int XLEN_DEF  = 32;
  localparam int NREGS_DEF = 32;
  localparam int NRD_DEF   = 2;

  typedef logic [4:0]  reg_addr_t;
  typedef logic [31:0] xword_t;
endpackage

// File: rtl/regfile_read_port.sv
// One registered read port of regfile_sb.
//   clk, reset_n        : clock, async active-low reset
//   rd_en, rd_addr      : read request for this port
//   regs                : current storage contents
//   busy_nxt            : scoreboard next-state (post-edge busy bits)
//   byp_en/addr/data    : this edge's committed write, bypassed into the read
//   rd_data, rd_busy    : registered result; held while rd_en=0
module regfile_read_port #(
  parameter  int XLEN     = 32,
  parameter  int NREGS    = 32,
  parameter  int ZERO_REG = 1,
  localparam int AW       = $clog2(NREGS)
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        rd_en,
  input  logic [AW-1:0]               rd_addr,
  input  logic [NREGS-1:0][XLEN-1:0]  regs,
  input  logic [NREGS-1:0]            busy_nxt,
  input  logic                        byp_en,
  input  logic [AW-1:0]               byp_addr,
  input  logic [XLEN-1:0]             byp_data,
  output logic [XLEN-1:0]             rd_data,
  output logic                        rd_busy
);
  logic [XLEN-1:0] rd_data_q, rd_data_d;
  logic            rd_busy_q, rd_busy_d;
  logic            is_zero;

  assign is_zero = (ZERO_REG != 0) && (rd_addr == '0);

  always_comb begin
    rd_data_d = rd_data_q;
    rd_busy_d = rd_busy_q;
    if (rd_en) begin
      if (is_zero) begin
        rd_data_d = '0;
        rd_busy_d = 1'b0;
      end else begin
        // byp_en already excludes zero-reg writes, so no extra masking here
        rd_data_d = (byp_en && byp_addr == rd_addr) ? byp_data : regs[rd_addr];
        rd_busy_d = busy_nxt[rd_addr];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_data_q <= '0;
      rd_busy_q <= 1'b0;
    end else begin
      rd_data_q <= rd_data_d;
      rd_busy_q <= rd_busy_d;
    end
  end

  assign rd_data = rd_data_q;
  assign rd_busy = rd_busy_q;
endmodule

// File: rtl/regfile_sb.sv
// Multi-port integer register file with busy-bit scoreboard.
//   clk, reset_n           : clock, async active-low reset
//   rd_en/rd_addr          : NRD read requests (packed, port p at [p*AW +: AW])
//   rd_data/rd_busy        : registered data and busy per port, 1-cycle latency
//   wr_en/wr_addr/wr_data  : result write, clears the register's busy bit
//   alloc_en/alloc_addr    : mark destination busy
//   flush                  : clear all busy bits
//   busy_vec               : stored busy bits
module regfile_sb
  import regfile_pkg::*;
#(
  parameter  int XLEN     = XLEN_DEF,
  parameter  int NREGS    = NREGS_DEF,
  parameter  int NRD      = NRD_DEF,
  parameter  int ZERO_REG = 1,
  localparam int AW       = $clog2(NREGS)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [NRD-1:0]       rd_en,
  input  logic [NRD*AW-1:0]    rd_addr,
  output logic [NRD*XLEN-1:0]  rd_data,
  output logic [NRD-1:0]       rd_busy,
  input  logic                 wr_en,
  input  logic [AW-1:0]        wr_addr,
  input  logic [XLEN-1:0]      wr_data,
  input  logic                 alloc_en,
  input  logic [AW-1:0]        alloc_addr,
  input  logic                 flush,
  output logic [NREGS-1:0]     busy_vec
);
  logic [NREGS-1:0][XLEN-1:0] regs_q, regs_d;
  logic [NREGS-1:0]           busy_q, busy_d;
  logic                       wr_ok, alloc_ok;

  assign wr_ok    = wr_en    && !((ZERO_REG != 0) && (wr_addr    == '0));
  assign alloc_ok = alloc_en && !((ZERO_REG != 0) && (alloc_addr == '0));

  always_comb begin
    regs_d = regs_q;
    if (wr_ok) regs_d[wr_addr] = wr_data;
  end

  // Priority: flush < write-clear < alloc-set, so a new producer always wins.
  always_comb begin
    busy_d = flush ? '0 : busy_q;
    if (wr_ok)    busy_d[wr_addr]    = 1'b0;
    if (alloc_ok) busy_d[alloc_addr] = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      regs_q <= '0;
      busy_q <= '0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
    end
  end

  assign busy_vec = busy_q;

  for (genvar p = 0; p < NRD; p++) begin : g_rp
    regfile_read_port #(
      .XLEN     (XLEN),
      .NREGS    (NREGS),
      .ZERO_REG (ZERO_REG)
    ) u_rp (
      .clk      (clk),
      .reset_n  (reset_n),
      .rd_en    (rd_en[p]),
      .rd_addr  (rd_addr[p*AW +: AW]),
      .regs     (regs_q),
      .busy_nxt (busy_d),
      .byp_en   (wr_ok),
      .byp_addr (wr_addr),
      .byp_data (wr_data),
      .rd_data  (rd_data[p*XLEN +: XLEN]),
      .rd_busy  (rd_busy[p])
    );
  end
endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: default build (a_*) plus a 4-port,
// 64-bit, 16-register build (b_*) sharing clock and reset.
module tb_regfile_sb;
  import regfile_pkg::*;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  // default build
  logic [1:0]  a_rd_en;
  logic [9:0]  a_rd_addr;
  logic [63:0] a_rd_data;
  logic [1:0]  a_rd_busy;
  logic        a_wr_en;
  reg_addr_t   a_wr_addr;
  xword_t      a_wr_data;
  logic        a_alloc_en;
  reg_addr_t   a_alloc_addr;
  logic        a_flush;
  logic [31:0] a_busy_vec;

  // wide build
  logic [3:0]   b_rd_en;
  logic [15:0]  b_rd_addr;
  logic [255:0] b_rd_data;
  logic [3:0]   b_rd_busy;
  logic         b_wr_en;
  logic [3:0]   b_wr_addr;
  logic [63:0]  b_wr_data;
  logic         b_alloc_en;
  logic [3:0]   b_alloc_addr;
  logic         b_flush;
  logic [15:0]  b_busy_vec;

  int n_chk  = 0;
  int n_fail = 0;

  regfile_sb u_dut_a (
    .clk(clk), .reset_n(reset_n),
    .rd_en(a_rd_en), .rd_addr(a_rd_addr), .rd_data(a_rd_data), .rd_busy(a_rd_busy),
    .wr_en(a_wr_en), .wr_addr(a_wr_addr), .wr_data(a_wr_data),
    .alloc_en(a_alloc_en), .alloc_addr(a_alloc_addr), .flush(a_flush),
    .busy_vec(a_busy_vec)
  );

  regfile_sb #(.XLEN(64), .NREGS(16), .NRD(4), .ZERO_REG(1)) u_dut_b (
    .clk(clk), .reset_n(reset_n),
    .rd_en(b_rd_en), .rd_addr(b_rd_addr), .rd_data(b_rd_data), .rd_busy(b_rd_busy),
    .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data),
    .alloc_en(b_alloc_en), .alloc_addr(b_alloc_addr), .flush(b_flush),
    .busy_vec(b_busy_vec)
  );

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // advance one edge; inputs change and outputs are sampled 1ns after it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic a_idle();
    a_rd_en = '0; a_wr_en = 0; a_alloc_en = 0; a_flush = 0;
  endtask

  localparam logic [63:0] PAT = 64'h0101010101010101;

  initial begin
    reset_n = 0;
    a_idle(); a_rd_addr = '0; a_wr_addr = '0; a_wr_data = '0; a_alloc_addr = '0;
    b_rd_en = '0; b_rd_addr = '0; b_wr_en = 0; b_wr_addr = '0; b_wr_data = '0;
    b_alloc_en = 0; b_alloc_addr = '0; b_flush = 0;
    #3;
    chk("rst_rd_data", a_rd_data, 64'h0);
    chk("rst_busy_vec", {32'h0, a_busy_vec}, 64'h0);
    tick(); tick();
    reset_n = 1;

    // write r5, alloc r6, then read r5; async reset mid-cycle clears everything
    a_wr_en = 1; a_wr_addr = 5; a_wr_data = 32'hDEADBEEF; a_alloc_en = 1; a_alloc_addr = 6;
    tick(); a_idle();
    chk("alloc_r6_busy_vec", {32'h0, a_busy_vec}, 64'h40);
    a_rd_en = 2'b01; a_rd_addr = {5'd0, 5'd5};
    tick(); a_idle();
    chk("rd_r5", {32'h0, a_rd_data[31:0]}, 64'hDEADBEEF);
    #2 reset_n = 0;
    #1;
    chk("midrst_rd_data", {32'h0, a_rd_data[31:0]}, 64'h0);
    chk("midrst_busy_vec", {32'h0, a_busy_vec}, 64'h0);
    @(posedge clk); #1 reset_n = 1;
    a_rd_en = 2'b01; a_rd_addr = {5'd0, 5'd5};
    tick(); a_idle();
    chk("rd_r5_after_rst", {32'h0, a_rd_data[31:0]}, 64'h0);

    // write r3 with same-cycle read (bypass), then port1 reads it
    a_wr_en = 1; a_wr_addr = 3; a_wr_data = 32'h12345678;
    a_rd_en = 2'b01; a_rd_addr = {5'd0, 5'd3};
    tick(); a_idle();
    chk("byp_p0_r3", {32'h0, a_rd_data[31:0]}, 64'h12345678);
    a_rd_en = 2'b10; a_rd_addr = {5'd3, 5'd0};
    tick(); a_idle();
    chk("p1_r3", {32'h0, a_rd_data[63:32]}, 64'h12345678);
    chk("p0_hold", {32'h0, a_rd_data[31:0]}, 64'h12345678);

    // r0 ignores write and alloc
    a_wr_en = 1; a_wr_addr = 0; a_wr_data = 32'hFFFFFFFF; a_alloc_en = 1; a_alloc_addr = 0;
    tick(); a_idle();
    a_rd_en = 2'b11; a_rd_addr = {5'd0, 5'd0};
    tick(); a_idle();
    chk("r0_p0", {32'h0, a_rd_data[31:0]}, 64'h0);
    chk("r0_p1", {32'h0, a_rd_data[63:32]}, 64'h0);
    chk("r0_rd_busy", {62'h0, a_rd_busy}, 64'h0);
    chk("r0_busy_vec", {32'h0, a_busy_vec}, 64'h0);

    // alloc r7 at N, read at N+1, write+read at N+3
    a_alloc_en = 1; a_alloc_addr = 7;
    tick(); a_idle();
    a_rd_en = 2'b01; a_rd_addr = {5'd0, 5'd7};
    tick(); a_idle();
    chk("r7_rd_busy", {63'h0, a_rd_busy[0]}, 64'h1);
    chk("r7_busy_vec", {32'h0, a_busy_vec}, 64'h80);
    tick();
    a_wr_en = 1; a_wr_addr = 7; a_wr_data = 32'hA5;
    a_rd_en = 2'b01; a_rd_addr = {5'd0, 5'd7};
    tick(); a_idle();
    chk("r7_busy_clr", {32'h0, a_busy_vec}, 64'h0);
    chk("r7_data", {32'h0, a_rd_data[31:0]}, 64'hA5);
    chk("r7_rd_busy_clr", {63'h0, a_rd_busy[0]}, 64'h0);

    // alloc+write same reg: data written, busy stays
    a_alloc_en = 1; a_alloc_addr = 9; a_wr_en = 1; a_wr_addr = 9; a_wr_data = 32'h55;
    tick(); a_idle();
    chk("r9_busy_vec", {32'h0, a_busy_vec}, 64'h200);
    a_rd_en = 2'b10; a_rd_addr = {5'd9, 5'd0};
    tick(); a_idle();
    chk("r9_data", {32'h0, a_rd_data[63:32]}, 64'h55);
    chk("r9_rd_busy", {63'h0, a_rd_busy[1]}, 64'h1);

    // flush with alloc r10 and write r11 (read on port1)
    a_flush = 1; a_alloc_en = 1; a_alloc_addr = 10;
    a_wr_en = 1; a_wr_addr = 11; a_wr_data = 32'h77;
    a_rd_en = 2'b11; a_rd_addr = {5'd11, 5'd9};
    tick(); a_idle();
    chk("flush_busy_vec", {32'h0, a_busy_vec}, 64'h400);
    chk("flush_r9_rd_busy", {63'h0, a_rd_busy[0]}, 64'h0);
    chk("flush_wr_r11", {32'h0, a_rd_data[63:32]}, 64'h77);
    // re-alloc of busy r10 keeps it busy
    a_alloc_en = 1; a_alloc_addr = 10; a_rd_en = 2'b01; a_rd_addr = {5'd0, 5'd10};
    tick(); a_idle();
    chk("realloc_r10", {63'h0, a_rd_busy[0]}, 64'h1);
    chk("realloc_busy_vec", {32'h0, a_busy_vec}, 64'h400);

    // wide build: fill r1..r15
    for (int i = 1; i < 16; i++) begin
      b_wr_en = 1; b_wr_addr = 4'(i); b_wr_data = 64'(i) * PAT;
      tick();
    end
    b_wr_en = 0;
    b_rd_en = 4'b1111; b_rd_addr = {4'd4, 4'd3, 4'd2, 4'd1};
    tick();
    chk("b_p0_r1", b_rd_data[63:0],    64'h0101010101010101);
    chk("b_p1_r2", b_rd_data[127:64],  64'h0202020202020202);
    chk("b_p2_r3", b_rd_data[191:128], 64'h0303030303030303);
    chk("b_p3_r4", b_rd_data[255:192], 64'h0404040404040404);
    b_rd_en = 4'b1011; b_rd_addr = {4'd0, 4'd9, 4'd8, 4'd15};
    tick();
    chk("b_p0_r15", b_rd_data[63:0],    64'h0F0F0F0F0F0F0F0F);
    chk("b_p1_r8",  b_rd_data[127:64],  64'h0808080808080808);
    chk("b_p2_hold", b_rd_data[191:128], 64'h0303030303030303);
    chk("b_p3_r0",  b_rd_data[255:192], 64'h0);
    b_rd_en = 4'b1111; b_rd_addr = {4'd12, 4'd12, 4'd12, 4'd12};
    tick();
    b_rd_en = '0;
    for (int p = 0; p < 4; p++)
      chk($sformatf("b_same_p%0d", p), b_rd_data[p*64 +: 64], 64'h0C0C0C0C0C0C0C0C);
    chk("b_busy_vec", {48'h0, b_busy_vec}, 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
